uart_alu: RTL and testbench
===========================

UART_ALU -- requirements
Module: uart_alu

Interface
REQ-001 SHALL have parameter datawidth_p, default 8: UART data bits per frame; only 8 is supported.
REQ-002 SHALL have parameter prescale_p, default 9: bit period = 8*prescale_p clk_i cycles (72 cycles at the default).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_i, input, 1 bit: UART serial in, idle high, asynchronous to clk_i.
REQ-006 SHALL have port tx_o, output, 1 bit: UART serial out, idle high.

Function
REQ-007 SHALL pass rx_i through a 2-flop synchronizer before any use.
REQ-008 SHALL receive 8N1 frames, LSB first:
- falling edge while idle starts a frame;
- start bit re-sampled 4*prescale_p cycles later, and if high the frame is aborted with the receiver back to idle;
- each data bit and the stop bit sampled 8*prescale_p cycles after the previous sample.
REQ-009 SHALL discard a received byte whose stop bit samples low (framing error), with the parser state unchanged.
REQ-010 SHALL transmit 8N1 frames, LSB first, each bit held for exactly 8*prescale_p cycles.
- Multi-byte responses are sent back-to-back: the next start bit immediately follows the previous stop bit.
REQ-011 SHALL implement a packet parser with states IDLE, GET_A, GET_B, RESPOND.
- IDLE: the first byte received is the opcode.
REQ-012 SHALL support these opcodes:
- 0x00 ECHO: one operand A; response A.
- 0x01 ADD: operands A, B; response {A+B}[7:0], then carry-out byte 0x00/0x01.
- 0x02 SUB: operands A, B; response {A-B}[7:0] mod 256, then borrow byte (0x01 if A<B, else 0x00).
- 0x03 MUL: operands A, B; response product[7:0], then product[15:8] (unsigned).
REQ-013 SHALL answer any other opcode with the single byte 0xEE, sent from RESPOND, and then return to IDLE.
REQ-014 SHALL start the first response start bit (tx_o falling) no more than 3 clk_i cycles after the stop-bit sample of the last operand (or opcode) byte.
REQ-015 SHALL drop bytes received while in RESPOND; the parser returns to IDLE one cycle after the last response stop bit completes.
REQ-016 SHALL accept the next packet's start bit as early as the cycle the response completes.
REQ-017 SHALL compute results combinationally from registered operands, with no extra latency beyond REQ-014.
REQ-018 SHALL continue receiving during transmission, so that receiver timing stays correct when a byte arrives during RESPOND.

Reset
REQ-019 SHALL, while rst_i is high, force tx_o=1 asynchronously.
REQ-020 SHALL, while rst_i is high, clear the parser to IDLE, the receiver and transmitter to idle, and all counters and operand registers to 0.
REQ-021 SHALL abort any frame in progress when reset is asserted mid-frame.
- No partial byte is delivered or resumed.
- tx_o stays high until a new response is started.
REQ-022 SHALL, after reset deasserts, not start a receive frame until rx_i has been sampled high (idle) at least once.

Configuration
REQ-023 SHALL, when UART_ALU_MUL_EN is defined, implement opcode 0x03 per REQ-012.
REQ-024 SHALL, when UART_ALU_MUL_EN is undefined:
- include no multiplier;
- accept no operands for opcode 0x03;
- treat 0x03 as unknown, responding 0xEE per REQ-013.

Verification
REQ-025 SHALL cover: reset held 10 cycles then released, idle 10 cycles -> tx_o=1 throughout.
REQ-026 SHALL cover: send 0x55 at the default prescale -> exactly one response frame 0xEE (bits 0,0,1,1,1,0,1,1,1,1 incl. start/stop, 72 cycles each), then idle.
REQ-027 SHALL cover: send 0x00, 0xA5 -> response 0xA5.
REQ-028 SHALL cover: send 0x01, 0xFF, 0x02 -> response 0x01 then 0x01; send 0x02, 0x03, 0x05 -> response 0xFE then 0x01.
REQ-029 SHALL cover: send 0x03, 0xFF, 0xFF with UART_ALU_MUL_EN defined -> 0x01, 0xFE; undefined -> 0xEE, then 0xFF and 0xFF are each parsed as opcodes, giving 0xEE per accepted byte.
REQ-030 SHALL cover: assert rst_i during the 4th bit of a response frame -> tx_o=1 immediately; then send 0x00, 0x3C -> response 0x3C.

Source files
------------

// File: rtl/uart_alu.sv
// uart_alu: byte-oriented ALU reached over an 8N1 UART link.
//
// A packet is an opcode byte followed by zero, one or two operand bytes.
// The answer is sent back on tx_o as one or two 8N1 frames.
//   0x00 ECHO  A     -> A
//   0x01 ADD   A B   -> (A+B)[7:0], carry (0x00/0x01)
//   0x02 SUB   A B   -> (A-B)[7:0], borrow (0x01 when A<B)
//   0x03 MUL   A B   -> product[7:0], product[15:8]  (only with UART_ALU_MUL_EN)
//   other            -> 0xEE
//
// Build option: define UART_ALU_MUL_EN to include the multiplier and opcode
// 0x03. Without it 0x03 is answered as an unknown opcode.
//
// Parameters:
//   datawidth_p  data bits per frame (only 8 is supported)
//   prescale_p   bit period is 8*prescale_p clk_i cycles
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset; forces tx_o high
//   rx_i   UART serial input, idle high, asynchronous to clk_i
//   tx_o   UART serial output, idle high
module uart_alu #(
  parameter int datawidth_p = 8,
  parameter int prescale_p  = 9
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o
);

  localparam int CNT_W = $clog2(8 * prescale_p);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(8 * prescale_p - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(4 * prescale_p - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [1:0] P_IDLE    = 2'd0;
  localparam logic [1:0] P_GET_A   = 2'd1;
  localparam logic [1:0] P_GET_B   = 2'd2;
  localparam logic [1:0] P_RESPOND = 2'd3;

  localparam logic [datawidth_p-1:0] OP_ECHO  = datawidth_p'(8'h00);
  localparam logic [datawidth_p-1:0] OP_ADD   = datawidth_p'(8'h01);
  localparam logic [datawidth_p-1:0] OP_SUB   = datawidth_p'(8'h02);
  localparam logic [datawidth_p-1:0] ERR_BYTE = datawidth_p'(8'hEE);
`ifdef UART_ALU_MUL_EN
  localparam logic [datawidth_p-1:0] OP_MUL   = datawidth_p'(8'h03);
`endif

  // ---------------------------------------------------------------------------
  // Input synchronizer. All three flops clear to 0 so no falling edge can be
  // seen after reset until rx has been sampled high at least once.
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // Receiver: half-bit delay to the start-bit centre, then one bit period
  // between samples. rx_valid pulses one cycle after a good stop sample.
  // ---------------------------------------------------------------------------
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit;
  logic [datawidth_p-1:0] r_shift;
  logic                   rx_valid;
  logic [datawidth_p-1:0] rx_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rx_fall) begin
            r_cnt   <= HALF_RELOAD;
            r_state <= R_START;
          end
        end
        R_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (rx_sync) begin
            r_state <= R_IDLE;
          end else begin
            r_cnt   <= BIT_RELOAD;
            r_bit   <= '0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_shift <= {rx_sync, r_shift[datawidth_p-1:1]};
            r_cnt   <= BIT_RELOAD;
            if (r_bit == 3'd7) r_state <= R_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        default: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= R_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_data  <= r_shift;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result datapath, purely combinational from the registered packet fields.
  // ---------------------------------------------------------------------------
  logic [datawidth_p-1:0] opcode, op_a, op_b;
  logic [datawidth_p-1:0] res_lo, res_hi;
  logic [datawidth_p:0]   sum, diff;

`ifdef UART_ALU_MUL_EN
  logic [2*datawidth_p-1:0] prod;
  assign prod = op_a * op_b;
`endif

  always_comb begin
    sum    = {1'b0, op_a} + {1'b0, op_b};
    diff   = {1'b0, op_a} - {1'b0, op_b};
    res_lo = ERR_BYTE;
    res_hi = '0;
    case (opcode)
      OP_ECHO: res_lo = op_a;
      OP_ADD: begin
        res_lo = sum[datawidth_p-1:0];
        res_hi = datawidth_p'(sum[datawidth_p]);
      end
      OP_SUB: begin
        // The 9th bit of the widened difference is the borrow.
        res_lo = diff[datawidth_p-1:0];
        res_hi = datawidth_p'(diff[datawidth_p]);
      end
`ifdef UART_ALU_MUL_EN
      OP_MUL: {res_hi, res_lo} = prod;
`endif
      default: ;
    endcase
  end

  function automatic logic has_two_operands(input logic [datawidth_p-1:0] op);
`ifdef UART_ALU_MUL_EN
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
`else
    return (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Packet parser. tx_pending launches the first response byte; the second
  // byte (if any) is loaded on the stop-bit end of the first so frames run
  // back-to-back.
  // ---------------------------------------------------------------------------
  logic [1:0] p_state;
  logic       tx_pending, resp_two, resp_idx;
  logic       tx_busy, tx_last, tx_load;
  logic [3:0] tx_bit;
  logic [CNT_W-1:0]       tx_cnt;
  logic [datawidth_p-1:0] tx_shift, tx_byte;

  assign tx_last = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);
  assign tx_load = (p_state == P_RESPOND) &&
                   (tx_pending || (tx_last && resp_two && !resp_idx));
  assign tx_byte = tx_pending ? res_lo : res_hi;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_state    <= P_IDLE;
      opcode     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      tx_pending <= 1'b0;
      resp_two   <= 1'b0;
      resp_idx   <= 1'b0;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (rx_valid) begin
            opcode <= rx_data;
            if ((rx_data == OP_ECHO) || has_two_operands(rx_data)) begin
              p_state <= P_GET_A;
            end else begin
              p_state    <= P_RESPOND;
              tx_pending <= 1'b1;
              resp_two   <= 1'b0;
              resp_idx   <= 1'b0;
            end
          end
        end
        P_GET_A: begin
          if (rx_valid) begin
            op_a <= rx_data;
            if (opcode == OP_ECHO) begin
              p_state    <= P_RESPOND;
              tx_pending <= 1'b1;
              resp_two   <= 1'b0;
              resp_idx   <= 1'b0;
            end else begin
              p_state <= P_GET_B;
            end
          end
        end
        P_GET_B: begin
          if (rx_valid) begin
            op_b       <= rx_data;
            p_state    <= P_RESPOND;
            tx_pending <= 1'b1;
            resp_two   <= 1'b1;
            resp_idx   <= 1'b0;
          end
        end
        default: begin
          // Received bytes are ignored here.
          if (tx_pending) begin
            tx_pending <= 1'b0;
          end else if (tx_last) begin
            if (resp_two && !resp_idx) resp_idx <= 1'b1;
            else                       p_state  <= P_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter. tx_bit: 0 = start, 1..8 = data, 9 = stop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_o     <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
    end else if (tx_load) begin
      tx_o     <= 1'b0;
      tx_busy  <= 1'b1;
      tx_shift <= tx_byte;
      tx_bit   <= '0;
      tx_cnt   <= BIT_RELOAD;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CNT_W'(1);
      end else begin
        tx_cnt <= BIT_RELOAD;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_o    <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == 4'd8) begin
            tx_o <= 1'b1;
          end else begin
            tx_o     <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_alu.sv
// tb_uart_alu: directed bench for uart_alu. Drives 8N1 frames on rx, decodes
// every frame on tx with a bit-timing monitor, and compares against a table
// of hand-computed responses plus a few reset/framing sequences.
module tb_uart_alu;

  localparam int P   = 9;
  localparam int BIT = 8 * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  always #5 clk = ~clk;

  uart_alu #(.datawidth_p(8), .prescale_p(P)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i (rx),
    .tx_o (tx)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stop_cyc = 0;

  always @(posedge clk) cyc++;

  // ---------------- tx frame monitor ----------------
  typedef struct {
    logic [7:0] data;
    bit         frame_ok;
    bit         timing_ok;
    int         fall_cyc;
  } frame_t;

  frame_t rxq[$];
  frame_t cur;
  logic   mon_prev = 1'b1;
  bit     mon_active = 1'b0;
  int     mon_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_prev   = tx;
    end else begin
      if (!mon_active) begin
        if (mon_prev && !tx) begin
          mon_active    = 1'b1;
          mon_cnt       = 0;
          cur.data      = '0;
          cur.frame_ok  = 1'b1;
          cur.timing_ok = 1'b1;
          cur.fall_cyc  = cyc;
        end
      end else begin
        mon_cnt++;
        if ((tx != mon_prev) && ((mon_cnt % BIT) != 0)) cur.timing_ok = 1'b0;
        if ((mon_cnt % BIT) == BIT / 2) begin
          if (mon_cnt / BIT == 0) begin
            if (tx) cur.frame_ok = 1'b0;
          end else if (mon_cnt / BIT == 9) begin
            if (!tx) cur.frame_ok = 1'b0;
          end else begin
            cur.data[mon_cnt / BIT - 1] = tx;
          end
        end
        if (mon_cnt == 10 * BIT - 1) begin
          mon_active = 1'b0;
          rxq.push_back(cur);
        end
      end
      mon_prev = tx;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_v;
    stop_cyc = cyc;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_resp(input string nm, input int n, input logic [7:0] o0,
                             input logic [7:0] o1);
    int   budget;
    logic [7:0] exp_b;
    budget = 4000;
    while ((rxq.size() < n) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    check({nm, "_arrived"}, (rxq.size() >= n), 1);
    if (rxq.size() >= n) begin
      for (int j = 0; j < n; j++) begin
        exp_b = (j == 0) ? o0 : o1;
        check($sformatf("%s_byte%0d", nm, j), rxq[j].data, exp_b);
        check($sformatf("%s_framing%0d", nm, j), rxq[j].frame_ok, 1);
        check($sformatf("%s_bittime%0d", nm, j), rxq[j].timing_ok, 1);
      end
      // Stop sample sits ~39 cycles into the stop bit; the reply may lag it by at most 3.
      check({nm, "_latency_ok"},
            ((rxq[0].fall_cyc - stop_cyc) >= 36) && ((rxq[0].fall_cyc - stop_cyc) <= 42), 1);
      if (n == 2) check({nm, "_back2back"}, rxq[1].fall_cyc - rxq[0].fall_cyc, 10 * BIT);
    end
    repeat (200) @(negedge clk);
    check({nm, "_no_extra"}, rxq.size(), n);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string          name;
    int             n_in;
    logic [2:0][7:0] din;
    int             n_out;
    logic [7:0]     o0;
    logic [7:0]     o1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input int ni, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input int no,
                              input logic [7:0] o0, input logic [7:0] o1);
    vec_t v;
    v.name   = nm;
    v.n_in   = ni;
    v.din[0] = a;
    v.din[1] = b;
    v.din[2] = c;
    v.n_out  = no;
    v.o0     = o0;
    v.o1     = o1;
    return v;
  endfunction

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("unknown_55",  1, 8'h55, 8'h00, 8'h00, 1, 8'hEE, 8'h00));
    vecs.push_back(mk("echo_a5",     2, 8'h00, 8'hA5, 8'h00, 1, 8'hA5, 8'h00));
    vecs.push_back(mk("add_carry",   3, 8'h01, 8'hFF, 8'h02, 2, 8'h01, 8'h01));
    vecs.push_back(mk("sub_borrow",  3, 8'h02, 8'h03, 8'h05, 2, 8'hFE, 8'h01));
    vecs.push_back(mk("add_nocarry", 3, 8'h01, 8'h10, 8'h20, 2, 8'h30, 8'h00));
    vecs.push_back(mk("sub_plain",   3, 8'h02, 8'h05, 8'h03, 2, 8'h02, 8'h00));
    vecs.push_back(mk("sub_equal",   3, 8'h02, 8'h07, 8'h07, 2, 8'h00, 8'h00));
    vecs.push_back(mk("add_max",     3, 8'h01, 8'hFF, 8'hFF, 2, 8'hFE, 8'h01));
    vecs.push_back(mk("echo_ff",     2, 8'h00, 8'hFF, 8'h00, 1, 8'hFF, 8'h00));
    vecs.push_back(mk("unknown_04",  1, 8'h04, 8'h00, 8'h00, 1, 8'hEE, 8'h00));
    vecs.push_back(mk("unknown_ff",  1, 8'hFF, 8'h00, 8'h00, 1, 8'hEE, 8'h00));
`ifdef UART_ALU_MUL_EN
    vecs.push_back(mk("mul_ffff",    3, 8'h03, 8'hFF, 8'hFF, 2, 8'h01, 8'hFE));
    vecs.push_back(mk("mul_0c0d",    3, 8'h03, 8'h0C, 8'h0D, 2, 8'h9C, 8'h00));
`else
    vecs.push_back(mk("mul_off_03",  1, 8'h03, 8'h00, 8'h00, 1, 8'hEE, 8'h00));
    vecs.push_back(mk("mul_off_ff1", 1, 8'hFF, 8'h00, 8'h00, 1, 8'hEE, 8'h00));
    vecs.push_back(mk("mul_off_ff2", 1, 8'hFF, 8'h00, 8'h00, 1, 8'hEE, 8'h00));
`endif

    // Reset held 10 cycles, then 10 idle cycles: line stays high.
    rst = 1'b1;
    rx  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_tx_high", tx, 1);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_tx_high", tx, 1);
    end

    foreach (vecs[v]) begin
      rxq.delete();
      for (int i = 0; i < vecs[v].n_in; i++) send_byte(vecs[v].din[i], 1'b1);
      expect_resp(vecs[v].name, vecs[v].n_out, vecs[v].o0, vecs[v].o1);
    end

    // Framing error on the operand byte: it is dropped, parser still waits for A.
    rxq.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h77, 1'b0);
    repeat (200) @(negedge clk);
    check("framing_err_silent", rxq.size(), 0);
    send_byte(8'h5A, 1'b1);
    expect_resp("framing_recover", 1, 8'h5A, 8'h00);

    // Short low glitch: start bit re-sample is high, so nothing is received.
    rxq.delete();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("false_start_quiet", rxq.size(), 0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h42, 1'b1);
    expect_resp("after_glitch", 1, 8'h42, 8'h00);

    // Reset during the 4th bit (data bit 2) of a response frame.
    rxq.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    begin
      int budget;
      budget = 2000;
      while (!(mon_active && mon_cnt >= 250) && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("resp_in_flight", (mon_active && mon_cnt >= 250), 1);
    end
    check("pre_reset_tx_bit2", tx, 0);
    rst = 1'b1;
    #1;
    check("async_reset_tx", tx, 1);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (!tx) lows++;
      end
      check("post_reset_tx_idle", lows, 0);
    end
    check("post_reset_no_frame", rxq.size(), 0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_resp("after_reset", 1, 8'h3C, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
